// File: rtl/dmem_pkg.sv
// Shared widths and helpers for the per-node data-memory responder.
// Used by dmem_array and dmem_responder.
package dmem_pkg;

  localparam int DWORD_W = 64;
  localparam int PADDR_W = 32;
  localparam int CNT_W   = 32;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // True when any address bit above the low aw index bits is set.
  function automatic logic addr_oor(input logic [0:PADDR_W-1] addr, input int aw);
    if (aw >= PADDR_W) return 1'b0;
    return (addr >> aw) != '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Plain synchronous single-port RAM: registered read data, write has priority.
// No reset on the storage or read register so the array stays SRAM-inferable.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [ADDR_W-1:0]  idx,
  input  logic [DWORD_W-1:0] wdata,
  output logic [DWORD_W-1:0] rdata
);

  logic [DWORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we)      mem[idx] <= wdata;
    else if (re) rdata    <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the processor data-memory port: 1-cycle read RAM with range
// check, sticky error flag and output hold. Optional DMEM_STATS_EN builds counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               memEn,
  input  logic               memWrEn,
  input  logic [0:PADDR_W-1] memAddr,
  input  logic [0:DWORD_W-1] memDataIn,
  output logic [0:DWORD_W-1] memDataOut,
  output logic               memErr,
  output logic [0:CNT_W-1]   rdCount,
  output logic [0:CNT_W-1]   wrCount
);

  logic [ADDR_W-1:0]  idx;
  logic               oor;
  logic               wr_ok, rd_ok, rd_bad, acc_bad;
  logic [DWORD_W-1:0] ram_rdata;
  logic [DWORD_W-1:0] hold_q;
  logic               rd_vld;

  assign idx     = memAddr[PADDR_W-ADDR_W:PADDR_W-1];
  assign oor     = CHECK_RANGE && addr_oor(memAddr, ADDR_W);
  assign wr_ok   = memEn &  memWrEn & ~oor;
  assign rd_ok   = memEn & ~memWrEn & ~oor;
  assign rd_bad  = memEn & ~memWrEn &  oor;
  assign acc_bad = memEn & oor;

  // Gating with reset keeps a write coincident with the reset edge from
  // landing anywhere unexpected.
  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (wr_ok & ~reset),
    .re    (rd_ok & ~reset),
    .idx   (idx),
    .wdata (memDataIn),
    .rdata (ram_rdata)
  );

  // The RAM read register cannot be reset, so the visible output is muxed
  // between fresh RAM data and a resettable copy of the last result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld <= 1'b0;
      hold_q <= '0;
    end else begin
      rd_vld <= rd_ok;
      if (rd_bad)      hold_q <= '0;
      else if (rd_vld) hold_q <= ram_rdata;
    end
  end

  assign memDataOut = rd_vld ? ram_rdata : hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        memErr <= 1'b0;
    else if (acc_bad) memErr <= 1'b1;
  end

`ifdef DMEM_STATS_EN
  logic [CNT_W-1:0] rd_cnt, wr_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_ok) rd_cnt <= sat_inc(rd_cnt);
      if (wr_ok) wr_cnt <= sat_inc(wr_cnt);
    end
  end

  assign rdCount = rd_cnt;
  assign wrCount = wr_cnt;
`else
  assign rdCount = '0;
  assign wrCount = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized check of dmem_responder (range-checked and wrapping builds side
// by side) against a word-array reference model.
module tb_dmem_responder;

`ifdef DMEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, we = 1'b0;
  logic [31:0] addr = '0;
  logic [63:0] din = '0;
  logic [63:0] dout0, dout1;
  logic        err0, err1;
  logic [31:0] rc0, wc0, rc1, wc1;

  dmem_responder #(.ADDR_W(8), .CHECK_RANGE(1'b1)) dut0 (
    .clk(clk), .reset(reset), .memEn(en), .memWrEn(we), .memAddr(addr),
    .memDataIn(din), .memDataOut(dout0), .memErr(err0), .rdCount(rc0), .wrCount(wc0));

  dmem_responder #(.ADDR_W(8), .CHECK_RANGE(1'b0)) dut1 (
    .clk(clk), .reset(reset), .memEn(en), .memWrEn(we), .memAddr(addr),
    .memDataIn(din), .memDataOut(dout1), .memErr(err1), .rdCount(rc1), .wrCount(wc1));

  always #5 clk = ~clk;

  // reference model, index 0 = range-checked, 1 = wrapping
  logic [63:0] mmem [2][256];
  bit          mknown [2][256];
  logic [63:0] mout [2];
  bit          mout_known [2];
  bit          merr [2];
  longint      mrd [2], mwr [2];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mout[k] = '0; mout_known[k] = 1'b1; merr[k] = 1'b0; mrd[k] = 0; mwr[k] = 0;
    end
  endtask

  task automatic model_step(input bit e, input bit w, input logic [31:0] a, input logic [63:0] d);
    for (int k = 0; k < 2; k++) begin
      bit oor;
      int i;
      oor = (k == 0) && (a > 32'd255);
      i   = int'(a % 32'd256);
      if (e) begin
        if (oor) begin
          merr[k] = 1'b1;
          if (!w) begin mout[k] = '0; mout_known[k] = 1'b1; end
        end else if (w) begin
          mmem[k][i] = d; mknown[k][i] = 1'b1;
          if (mwr[k] < 64'hFFFF_FFFF) mwr[k]++;
        end else begin
          mout[k] = mmem[k][i]; mout_known[k] = mknown[k][i];
          if (mrd[k] < 64'hFFFF_FFFF) mrd[k]++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] o, r, w;
    logic        er;
    for (int k = 0; k < 2; k++) begin
      o  = (k == 0) ? dout0 : dout1;
      er = (k == 0) ? err0 : err1;
      r  = {32'b0, (k == 0) ? rc0 : rc1};
      w  = {32'b0, (k == 0) ? wc0 : wc1};
      if (mout_known[k]) chk($sformatf("%s.out%0d", tag, k), o, mout[k]);
      chk($sformatf("%s.err%0d", tag, k), {63'b0, er}, {63'b0, merr[k]});
      chk($sformatf("%s.rd%0d", tag, k), r, STATS ? 64'(mrd[k]) : 64'd0);
      chk($sformatf("%s.wr%0d", tag, k), w, STATS ? 64'(mwr[k]) : 64'd0);
    end
  endtask

  task automatic op(input string tag, input bit e, input bit w, input logic [31:0] a,
                    input logic [63:0] d);
    @(negedge clk);
    en = e; we = w; addr = a; din = d;
    @(posedge clk);
    model_step(e, w, a, d);
    #1 check_all(tag);
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) begin mknown[k][i] = 1'b0; mmem[k][i] = '0; end
    model_reset();
    #1 check_all("reset");
    @(negedge clk) reset = 1'b0;

    // write then read back with latency one
    op("t1_wr", 1, 1, 32'd5, 64'hDEAD_BEEF_0123_4567);
    op("t1_rd", 1, 0, 32'd5, 64'h0);
    chk("t1_data", dout0, 64'hDEAD_BEEF_0123_4567);

    // output hold across idles and a write
    op("t2_rd", 1, 0, 32'd5, 64'h0);
    for (int i = 0; i < 3; i++) op("t2_idle", 0, 1'($urandom), $urandom, 64'h0);
    op("t2_wr", 1, 1, 32'd6, 64'h1234);
    chk("t2_hold", dout0, 64'hDEAD_BEEF_0123_4567);

    // out-of-range write and read on the checked build
    op("t3_wr0", 1, 1, 32'd0, 64'h0BAD_F00D);
    op("t3_oorwr", 1, 1, 32'h100, 64'h1);
    op("t3_rd0", 1, 0, 32'd0, 64'h0);
    chk("t3_addr0", dout0, 64'h0BAD_F00D);
    op("t3_oorrd", 1, 0, 32'h100, 64'h0);
    chk("t3_zero", dout0, 64'h0);
    op("t3_idle", 0, 0, 32'h0, 64'h0);

    // wrapping build aliases 0x103 onto index 3
    op("t4_wr", 1, 1, 32'h0000_0103, 64'hA5);
    op("t4_rd", 1, 0, 32'h3, 64'h0);
    chk("t4_wrap", dout1, 64'hA5);

    // mid-cycle async reset; array contents persist
    op("t6_wr", 1, 1, 32'd7, 64'hCAFE_0007_0007_CAFE);
    op("t6_idle", 0, 0, 32'd0, 64'h0);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("t6_async");
    @(negedge clk) reset = 1'b0;
    op("t6_rd", 1, 0, 32'd7, 64'h0);
    chk("t6_keep", dout0, 64'hCAFE_0007_0007_CAFE);

    // full sweep with data = index*3
    for (int i = 0; i < 256; i++) begin
      op("t5_wr", 1, 1, 32'(i), 64'(i * 3));
      op("t5_rd", 1, 0, 32'(i), 64'h0);
    end

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 7) == 0) ? 32'd256 + $urandom_range(0, 5000) : $urandom_range(0, 255);
      if (r < 2)      op("rnd_idle", 0, 1'($urandom), $urandom, {$urandom, $urandom});
      else if (r < 6) op("rnd_wr", 1, 1, a, {$urandom, $urandom});
      else            op("rnd_rd", 1, 0, a, 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
